iob_sram_arb: RTL

IOB_SRAM_ARB -- requirements
Module: iob_sram_arb

---
 rtl/iob_sram_arb_pkg.sv | 23 ++
 rtl/iob_sram_arb_rr.sv | 61 ++++++
 rtl/iob_sram_arb.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/iob_sram_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : iob_sram_arb_pkg                                       |
// | Description : Shared FSM state encoding and requester tags for the   |
// |               boot / data / instruction SRAM arbiter.                |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package iob_sram_arb_pkg;

  // Arbiter FSM: boot loader owns the SRAM (LOAD), CPU buses share it
  // (RUN), or outstanding CPU reads are retired before handing back (DRAIN).
  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Requester tags used for the pending-read entry and the last-grant pointer.
  localparam logic TAG_D = 1'b0;
  localparam logic TAG_I = 1'b1;

endpackage
`default_nettype wire

// File: rtl/iob_sram_arb_rr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : iob_sram_arb_rr                                        |
// | Description : Two-requester (data / instruction) grant logic.        |
// |               IOB_SRAM_ARB_RR_EN defined : round-robin on conflicts, |
// |               data bus wins the first conflict after reset.          |
// |               IOB_SRAM_ARB_RR_EN undefined: fixed data-bus priority. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module iob_sram_arb_rr
  import iob_sram_arb_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,      // grants allowed only while the CPU owns the SRAM
  input  logic d_req_i,
  input  logic i_req_i,
  output logic d_gnt_o,
  output logic i_gnt_o
);

`ifdef IOB_SRAM_ARB_RR_EN
  logic last_q;
  logic last_d;

  // Conflict goes to the requester not granted last; the pointer follows
  // every grant, conflicting or not.
  always_comb begin
    d_gnt_o = en_i && d_req_i && (!i_req_i || (last_q == TAG_I));
    i_gnt_o = en_i && i_req_i && !d_gnt_o;
    last_d  = last_q;
    if (d_gnt_o) begin
      last_d = TAG_D;
    end else if (i_gnt_o) begin
      last_d = TAG_I;
    end
  end

  // Last-grant pointer; reset to I so the data bus wins the first conflict.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= TAG_I;
    end else begin
      last_q <= last_d;
    end
  end
`else
  logic unused_clk_rst;

  // Fixed priority: the data bus always wins a conflict.
  always_comb begin
    d_gnt_o = en_i && d_req_i;
    i_gnt_o = en_i && i_req_i && !d_req_i;
  end

  // No state in fixed-priority mode; clock and reset are intentionally idle.
  assign unused_clk_rst = ^{clk_i, rst_i};
`endif

endmodule
`default_nettype wire

// File: rtl/iob_sram_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : iob_sram_arb                                           |
// | Description : Single-port SRAM arbiter. A boot loader write port     |
// |               owns the SRAM in LOAD; data and instruction buses      |
// |               share it in RUN; DRAIN retires the last read before    |
// |               returning to LOAD. Read data is 1-cycle latency.       |
// |               Config macro: IOB_SRAM_ARB_RR_EN (round-robin mode,    |
// |               consumed by iob_sram_arb_rr).                          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module iob_sram_arb
  import iob_sram_arb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int SRAM_ADDR_W = 15
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     boot_i,
  // boot loader write port
  input  logic                     b_avalid_i,
  input  logic [ADDR_W-1:0]        b_addr_i,
  input  logic [DATA_W-1:0]        b_wdata_i,
  input  logic [DATA_W/8-1:0]      b_wstrb_i,
  output logic                     b_ready_o,
  // data bus
  input  logic                     d_avalid_i,
  input  logic [ADDR_W-1:0]        d_addr_i,
  input  logic [DATA_W-1:0]        d_wdata_i,
  input  logic [DATA_W/8-1:0]      d_wstrb_i,
  output logic                     d_ready_o,
  output logic                     d_rvalid_o,
  output logic [DATA_W-1:0]        d_rdata_o,
  // instruction bus (read only)
  input  logic                     i_avalid_i,
  input  logic [ADDR_W-1:0]        i_addr_i,
  output logic                     i_ready_o,
  output logic                     i_rvalid_o,
  output logic [DATA_W-1:0]        i_rdata_o,
  // SRAM
  output logic                     sram_en_o,
  output logic [DATA_W/8-1:0]      sram_wstrb_o,
  output logic [SRAM_ADDR_W-3:0]   sram_addr_o,
  output logic [DATA_W-1:0]        sram_wdata_o,
  input  logic [DATA_W-1:0]        sram_rdata_i
);

  state_t state_q, state_d;
  logic   pend_q, pend_d;     // one outstanding read
  logic   tag_q, tag_d;       // which bus owns the outstanding read
  logic   run_en;
  logic   d_gnt, i_gnt;
  logic   unused_addr;

  assign run_en = (state_q == ST_RUN);

  iob_sram_arb_rr u_rr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (run_en),
    .d_req_i (d_avalid_i),
    .i_req_i (i_avalid_i),
    .d_gnt_o (d_gnt),
    .i_gnt_o (i_gnt)
  );

  // Next state plus the ownership-dependent handshake and SRAM mux.
  always_comb begin
    state_d      = state_q;
    b_ready_o    = 1'b0;
    d_ready_o    = 1'b0;
    i_ready_o    = 1'b0;
    sram_en_o    = 1'b0;
    sram_wstrb_o = '0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    case (state_q)
      ST_LOAD: begin
        b_ready_o    = b_avalid_i;
        sram_en_o    = b_avalid_i;
        sram_wstrb_o = b_wstrb_i;
        sram_addr_o  = b_addr_i[SRAM_ADDR_W-1:2];
        sram_wdata_o = b_wdata_i;
        // A write in flight finishes first; the exit test repeats next cycle.
        if (!boot_i && !b_avalid_i) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        d_ready_o    = d_gnt;
        i_ready_o    = i_gnt;
        sram_en_o    = d_gnt | i_gnt;
        sram_addr_o  = i_gnt ? i_addr_i[SRAM_ADDR_W-1:2] : d_addr_i[SRAM_ADDR_W-1:2];
        sram_wstrb_o = d_gnt ? d_wstrb_i : '0;
        sram_wdata_o = d_wdata_i;
        if (boot_i) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!pend_q) begin
          state_d = ST_LOAD;
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // A granted read (instruction bus, or data bus with zero strobes) opens
  // the pending entry; grants exist only in RUN, so DRAIN lets it retire.
  always_comb begin
    pend_d = (d_gnt && (d_wstrb_i == '0)) || i_gnt;
    tag_d  = i_gnt ? TAG_I : TAG_D;
  end

  // State and pending-read registers; reset discards any outstanding read.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_LOAD;
      pend_q  <= 1'b0;
      tag_q   <= TAG_D;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      tag_q   <= tag_d;
    end
  end

  assign d_rvalid_o = pend_q && (tag_q == TAG_D);
  assign i_rvalid_o = pend_q && (tag_q == TAG_I);
  assign d_rdata_o  = sram_rdata_i;
  assign i_rdata_o  = sram_rdata_i;

  // Only the word-address slice of each requester address reaches the SRAM.
  assign unused_addr = ^{b_addr_i, d_addr_i, i_addr_i};

endmodule
`default_nettype wire
